// File: rtl/bitcnt_pkg.sv
// Shared types for the iterative count-leading/trailing/pop sequencer:
// operation codes, FSM state encodings and byte scan modes.
package bitcnt_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      OP_CLZ = 2'b00,
      OP_CLO = 2'b01,
      OP_CTZ = 2'b10,
      OP_POP = 2'b11
   } bitcnt_op_t;

   // FSM state encodings, kept as plain constants so older tools and
   // waveform scripts can match on raw values.
   typedef logic [1:0] bitcnt_state_t;
   localparam bitcnt_state_t ST_IDLE = 2'd0;
   localparam bitcnt_state_t ST_SCAN = 2'd1;
   localparam bitcnt_state_t ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      SCAN_LZ  = 2'd0,
      SCAN_TZ  = 2'd1,
      SCAN_POP = 2'd2
   } scan_mode_t;

   // Byte count that means "the whole byte was zero" (LZ/TZ modes).
   localparam logic [3:0] BYTE_FULL = 4'd8;

   // Byte index of the first byte scanned for a given operation:
   // leading counts start at the top byte, the others at the bottom.
   function automatic logic [1:0] first_idx(input bitcnt_op_t o);
      logic [1:0] r;
      case (o)
         OP_CLZ, OP_CLO: r = 2'd3;
         OP_CTZ, OP_POP: r = 2'd0;
         default:        r = 2'd0;
      endcase
      return r;
   endfunction

   // Scan mode used by the shared byte unit for a given operation.
   function automatic scan_mode_t op_mode(input bitcnt_op_t o);
      scan_mode_t m;
      case (o)
         OP_CLZ, OP_CLO: m = SCAN_LZ;
         OP_CTZ:         m = SCAN_TZ;
         OP_POP:         m = SCAN_POP;
         default:        m = SCAN_POP;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bitcount_seq_byte_scan.sv
// Combinational 8-bit scan unit: leading-zero, trailing-zero or popcount
// of one byte, result 0..8.
module byte_scan
   import bitcnt_pkg::*;
(
   input  logic [7:0] val,
   input  logic [1:0] mode,
   output logic [3:0] cnt
);

   logic [3:0] lz;
   logic [3:0] tz;
   logic [3:0] pc;

   // Leading zeros: the highest set bit seen last determines the count.
   always_comb begin
      lz = BYTE_FULL;
      for (int i = 0; i < 8; i++) begin
         if (val[i]) begin
            lz = 4'd7 - 4'(i);
         end else begin
            lz = lz;
         end
      end
   end

   // Trailing zeros: scanning downward, the lowest set bit is seen last.
   always_comb begin
      tz = BYTE_FULL;
      for (int i = 7; i >= 0; i--) begin
         if (val[i]) begin
            tz = 4'(i);
         end else begin
            tz = tz;
         end
      end
   end

   // Population count of the byte.
   always_comb begin
      pc = 4'd0;
      for (int i = 0; i < 8; i++) begin
         pc = pc + {3'b000, val[i]};
      end
   end

   // Select the count for the requested mode.
   always_comb begin
      case (scan_mode_t'(mode))
         SCAN_LZ:  cnt = lz;
         SCAN_TZ:  cnt = tz;
         SCAN_POP: cnt = pc;
         default:  cnt = 4'd0;
      endcase
   end

endmodule

// File: rtl/bitcount_seq.sv
// Multi-cycle CLZ/CLO/CTZ/POPCNT sequencer. One shared byte scan unit walks
// the operand a byte per cycle, optionally stopping at the first byte that
// is not all-zero. Raises a stall request while busy and honours flush.
module bitcount_seq
   import bitcnt_pkg::*;
#(
   parameter int EARLY_EXIT = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand,
   input  logic        flush,
   output logic        busy,
   output logic        stall_req,
   output logic        result_valid,
   output logic [31:0] result
);

   bitcnt_state_t state;
   bitcnt_state_t state_next;

   bitcnt_op_t    op_in;
   bitcnt_op_t    op_q;
   word_t         data_q;
   logic [5:0]    acc;
   logic [5:0]    acc_next;
   logic [1:0]    idx;
   logic [1:0]    idx_next;
   logic          hit;

   logic          accept;
   logic          scan_step;
   logic          finish;
   logic          byte_stop;
   logic          early;
   logic [7:0]    cur_byte;
   logic [3:0]    cnt;
   logic [3:0]    add;
   scan_mode_t    mode;

   assign op_in     = bitcnt_op_t'(op);
   assign early     = (EARLY_EXIT != 0);
   assign busy      = (state == ST_SCAN);
   assign accept    = start & ~busy & ~flush;
   assign stall_req = busy | accept;
   assign scan_step = busy & ~flush;
   assign mode      = op_mode(op_q);

   // Pick the byte currently under the scan unit.
   always_comb begin
      case (idx)
         2'd0:    cur_byte = data_q[7:0];
         2'd1:    cur_byte = data_q[15:8];
         2'd2:    cur_byte = data_q[23:16];
         2'd3:    cur_byte = data_q[31:24];
         default: cur_byte = 8'd0;
      endcase
   end

   byte_scan u_byte_scan (
      .val  (cur_byte),
      .mode (mode),
      .cnt  (cnt)
   );

   // Accumulate, masking every byte after the first non-full one so a
   // full scan (no early exit) still yields the boundary-limited count.
   always_comb begin
      byte_stop = (op_q != OP_POP) && (cnt != BYTE_FULL);
      if (hit) begin
         add = 4'd0;
      end else begin
         add = cnt;
      end
      acc_next = acc + {2'b00, add};
   end

   // Termination test and byte walk direction for the current operation.
   always_comb begin
      case (op_q)
         OP_CLZ, OP_CLO: begin
            finish   = (early && byte_stop) || (idx == 2'd0);
            idx_next = idx - 2'd1;
         end
         OP_CTZ: begin
            finish   = (early && byte_stop) || (idx == 2'd3);
            idx_next = idx + 2'd1;
         end
         OP_POP: begin
            finish   = (idx == 2'd3);
            idx_next = idx + 2'd1;
         end
         default: begin
            finish   = 1'b1;
            idx_next = idx;
         end
      endcase
   end

   // Next-state logic; flush always returns to IDLE and beats a start.
   always_comb begin
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state_next = ST_SCAN;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (finish) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_SCAN;
               end
            end
            ST_DONE: begin
               if (accept) begin
                  state_next = ST_SCAN;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operation latch on accept, then per-byte accumulation while scanning.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_CLZ;
         data_q <= 32'd0;
         acc    <= 6'd0;
         idx    <= 2'd0;
         hit    <= 1'b0;
      end else if (accept) begin
         op_q   <= op_in;
         data_q <= (op_in == OP_CLO) ? ~operand : operand;
         acc    <= 6'd0;
         idx    <= first_idx(op_in);
         hit    <= 1'b0;
      end else if (scan_step) begin
         acc    <= acc_next;
         idx    <= finish ? idx : idx_next;
         hit    <= hit | byte_stop;
      end else begin
         op_q   <= op_q;
         data_q <= data_q;
         acc    <= acc;
         idx    <= idx;
         hit    <= hit;
      end
   end

   // Result register and one-cycle valid pulse; the result is held
   // until the next completed operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         result       <= 32'd0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= scan_step & finish;
         if (scan_step && finish) begin
            result <= {26'd0, acc_next};
         end else begin
            result <= result;
         end
      end
   end

endmodule

// File: tb/tb_bitcount_seq.sv
// Self-checking bench for bitcount_seq: directed scenarios plus randomized
// operations checked against a bit-level reference model. Two instances run
// side by side, one with early exit and one without.
module tb_bitcount_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand;
   logic        flush;

   logic        busy1, stall1, rv1;
   logic [31:0] result1;
   logic        busy0, stall0, rv0;
   logic [31:0] result0;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int          n;
      int          first;
      int          last;
      logic [31:0] rfirst;
      logic [31:0] rlast;
      logic        stall_first;
   } obs_t;

   bitcount_seq #(.EARLY_EXIT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
      .flush(flush), .busy(busy1), .stall_req(stall1),
      .result_valid(rv1), .result(result1)
   );

   bitcount_seq #(.EARLY_EXIT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
      .flush(flush), .busy(busy0), .stall_req(stall0),
      .result_valid(rv0), .result(result0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: count computed directly on the 32-bit word.
   function automatic int ref_count(input logic [1:0] o, input logic [31:0] v);
      int n = 0;
      case (o)
         2'b00: while (n < 32 && v[31-n] == 1'b0) n++;
         2'b01: while (n < 32 && v[31-n] == 1'b1) n++;
         2'b10: while (n < 32 && v[n] == 1'b0) n++;
         default: n = $countones(v);
      endcase
      return n;
   endfunction

   // Reference latency with early exit: bytes until the hit byte, plus one.
   function automatic int ref_lat(input logic [1:0] o, input int c);
      int b;
      if (o == 2'b11) return 5;
      b = c / 8 + 1;
      if (b > 4) b = 4;
      return b + 1;
   endfunction

   // Watch cycles k0..k1 (entered #1 after the edge starting cycle k0).
   task automatic watch(input int k0, input int k1, output obs_t o1, output obs_t o0);
      o1 = '{0, 0, 0, 32'd0, 32'd0, 1'b0};
      o0 = '{0, 0, 0, 32'd0, 32'd0, 1'b0};
      for (int k = k0; k <= k1; k++) begin
         if (rv1 === 1'b1) begin
            if (o1.n == 0) begin o1.first = k; o1.rfirst = result1; o1.stall_first = stall1; end
            o1.n++; o1.last = k; o1.rlast = result1;
         end
         if (rv0 === 1'b1) begin
            if (o0.n == 0) begin o0.first = k; o0.rfirst = result0; o0.stall_first = stall0; end
            o0.n++; o0.last = k; o0.rlast = result0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] v, input int exp,
                        input int lat1, input string tag);
      obs_t a1, a0;
      @(negedge clk);
      op = o; operand = v; start = 1'b1;
      #1;
      check({tag, "/stall_start"}, {31'd0, stall1}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "/busy_c1"}, {30'd0, busy1, busy0}, 32'd3);
      watch(1, 8, a1, a0);
      check({tag, "/n_valid"}, a1.n, 1);
      check({tag, "/latency"}, a1.first, lat1);
      check({tag, "/result"}, a1.rfirst, exp);
      check({tag, "/stall_done"}, {31'd0, a1.stall_first}, 32'd0);
      check({tag, "/noee_n_valid"}, a0.n, 1);
      check({tag, "/noee_latency"}, a0.first, 5);
      check({tag, "/noee_result"}, a0.rfirst, exp);
   endtask

   initial begin
      obs_t a1, a0, b1, b0;
      logic [31:0] v;
      logic [1:0]  o;
      int          sh;
      int          c;

      rst = 1'b1; start = 1'b0; op = 2'b00; operand = 32'd0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/busy", {31'd0, busy1}, 32'd0);
      check("reset/valid", {31'd0, rv1}, 32'd0);
      check("reset/result", result1, 32'd0);
      check("reset/stall", {31'd0, stall1}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Reset in the second SCAN cycle discards the operation.
      @(negedge clk); op = 2'b00; operand = 32'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      check("rst_mid/busy", {30'd0, busy1, busy0}, 32'd0);
      check("rst_mid/result", result1, 32'd0);
      check("rst_mid/valid", {30'd0, rv1, rv0}, 32'd0);
      do_op(2'b00, 32'h0000_0001, 31, 5, "clz_1");

      // Early exit and full-scan directed cases.
      do_op(2'b00, 32'h8000_0000, 0, 2, "clz_msb");
      do_op(2'b10, 32'h0000_0100, 8, 3, "ctz_100");
      do_op(2'b01, 32'hFF7F_FFFF, 8, 3, "clo_ff7f");
      do_op(2'b11, 32'hF0F0_00FF, 16, 5, "pop_f0f0");
      do_op(2'b10, 32'h0000_0000, 32, 5, "ctz_zero");
      do_op(2'b01, 32'hFFFF_FFFF, 32, 5, "clo_ones");
      do_op(2'b00, 32'h0010_0000, 11, 3, "clz_masked");

      // Start during SCAN is ignored.
      @(negedge clk); op = 2'b11; operand = 32'h0F0F_0F0F; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; op = 2'b00; operand = 32'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      watch(3, 8, a1, a0);
      check("ign/n_valid", a1.n, 1);
      check("ign/latency", a1.first, 5);
      check("ign/result", a1.rfirst, 32'd16);
      check("ign/noee_result", a0.rfirst, 32'd16);
      check("ign/idle_after", {30'd0, busy1, busy0}, 32'd0);

      // Flush in SCAN together with start: back to IDLE, nothing taken.
      @(negedge clk); op = 2'b00; operand = 32'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; flush = 1'b1; start = 1'b1; op = 2'b11; operand = 32'hFFFF_FFFF;
      @(posedge clk); #1; flush = 1'b0; start = 1'b0;
      check("flush/busy", {30'd0, busy1, busy0}, 32'd0);
      watch(3, 9, a1, a0);
      check("flush/n_valid", a1.n + a0.n, 0);
      check("flush/result", result1, 32'd16);
      check("flush/noee_result", result0, 32'd16);
      check("flush/idle", {30'd0, busy1, busy0}, 32'd0);

      // Back-to-back issue with start held high.
      @(negedge clk); op = 2'b11; operand = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1; op = 2'b00; operand = 32'h0001_0000;
      watch(1, 5, a1, a0);
      start = 1'b0;
      check("b2b/no_gap", {30'd0, busy1, busy0}, 32'd3);
      watch(6, 13, b1, b0);
      check("b2b/first_lat", a1.first, 5);
      check("b2b/first_res", a1.rfirst, 32'd32);
      check("b2b/second_n", b1.n, 1);
      check("b2b/second_lat", b1.first, 8);
      check("b2b/second_res", b1.rfirst, 32'd15);
      check("b2b/noee_second_lat", b0.first, 10);
      check("b2b/noee_second_res", b0.rfirst, 32'd15);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         o  = 2'($urandom_range(0, 3));
         v  = $urandom;
         sh = $urandom_range(0, 31);
         case ($urandom_range(0, 4))
            0: v = v >> sh;
            1: v = v << sh;
            2: v = ~(v >> sh);
            3: v = ~(v << sh);
            default: v = v;
         endcase
         if ($urandom_range(0, 15) == 0) v = 32'd0;
         c = ref_count(o, v);
         do_op(o, v, c, ref_lat(o, c), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
